reset_seq: RTL



---
 rtl/reset_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/reset_seq.sv
// Reset sequencer for the Propeller core: releases nres only after PLL lock has been stable for HOLD_CYCLES.
// Optional define RESET_CAUSE_EN records the cause of the last reset in res_cause (else tied to 2'b00).
//
// state   | meaning
// S_RESET | waiting for the pin-reset synchronizer to fill
// S_LOCK  | waiting for synchronized PLL lock
// S_HOLD  | counting continuous lock cycles before release
// S_RUN   | core running, nres=1
// S_SWRES | software reset pulse, minimum SW_CYCLES long
module reset_seq #(
    parameter int CNT_W       = 24,
    parameter int HOLD_CYCLES = 16,
    parameter int SW_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       inp_resn,
    input  logic       pll_lock,
    input  logic       sw_res,
    output logic       nres,
    output logic       reset_to,
    output logic [1:0] res_cause
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_LOCK  = 3'd1,
        S_HOLD  = 3'd2,
        S_RUN   = 3'd3,
        S_SWRES = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       rsync;
    logic [1:0]       lsync;
    logic [1:0]       ssync;

    always_ff @(posedge clk or negedge inp_resn) begin
        if (!inp_resn) begin
            rsync <= 2'b00;
            lsync <= 2'b00;
            ssync <= 2'b00;
        end else begin
            rsync <= {rsync[0], 1'b1};
            lsync <= {lsync[0], pll_lock};
            ssync <= {ssync[0], sw_res};
        end
    end

    always_ff @(posedge clk or negedge inp_resn) begin
        if (!inp_resn) begin
            state    <= S_RESET;
            cnt      <= '0;
            nres     <= 1'b0;
            reset_to <= 1'b0;
        end else begin
            reset_to <= 1'b0;
            case (state)
                S_RESET: begin
                    cnt  <= '0;
                    nres <= 1'b0;
                    if (rsync[1]) state <= S_LOCK;
                end
                S_LOCK: begin
                    cnt  <= '0;
                    nres <= 1'b0;
                    if (lsync[1]) state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!lsync[1]) begin
                        state <= S_LOCK;
                        cnt   <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state    <= S_RUN;
                        cnt      <= '0;
                        nres     <= 1'b1;
                        reset_to <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // lock loss wins over a simultaneous software request
                    if (!lsync[1]) begin
                        state <= S_LOCK;
                        nres  <= 1'b0;
                    end else if (ssync[1]) begin
                        state <= S_SWRES;
                        cnt   <= '0;
                        nres  <= 1'b0;
                    end
                end
                S_SWRES: begin
                    nres <= 1'b0;
                    if (!lsync[1]) begin
                        state <= S_LOCK;
                        cnt   <= '0;
                    end else if (cnt == SW_LAST && !ssync[1]) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end else if (cnt != SW_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_RESET;
                    cnt   <= '0;
                    nres  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RESET_CAUSE_EN
    // Mirrors the FSM exits into S_LOCK (lock loss) and S_RUN->S_SWRES.
    always_ff @(posedge clk or negedge inp_resn) begin
        if (!inp_resn) begin
            res_cause <= 2'b00;
        end else if ((state == S_HOLD || state == S_RUN || state == S_SWRES) && !lsync[1]) begin
            res_cause <= 2'b01;
        end else if (state == S_RUN && ssync[1]) begin
            res_cause <= 2'b10;
        end
    end
`else
    assign res_cause = 2'b00;
`endif

endmodule
